// File: rtl/spi_adc_scan_master.sv
// ---------------------------------------------------------------------------
// spi_adc_scan_master
//
// SPI master for multi-channel serial ADCs. Each frame drives a command word
// (start bit, channel number, zero padding) out on mosi and shifts FRAME_W
// samples in from miso. The low DATA_W samples become the result, which is
// tagged with the channel it came from. Frames are started either by a
// single-shot start/ch_sel request or by continuous round-robin scanning.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   start      single-shot request, only looked at while idle
//   ch_sel     channel for a single-shot request (out of range -> channel 0)
//   scan_en    continuous round-robin scan, has priority over start
//   busy       high from frame acceptance until the inter-frame gap ends
//   data       last result, MSB first as received
//   data_ch    channel that produced data
//   data_valid one-cycle pulse when data/data_ch update
//   sclk       SPI clock, idles at CPOL
//   cs_n       chip select, active low
//   mosi       command bit stream
//   miso       ADC data in
// ---------------------------------------------------------------------------
module spi_adc_scan_master #(
    parameter int DATA_W  = 12,
    parameter int FRAME_W = 16,
    parameter int NUM_CH  = 8,
    parameter int CH_W    = 3,
    parameter int CLK_DIV = 4,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              scan_en,
    output logic              busy,
    output logic [DATA_W-1:0] data,
    output logic [CH_W-1:0]   data_ch,
    output logic              data_valid,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TOG_W = $clog2(2 * FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * FRAME_W);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TOG_W-1:0]    tog_q, tog_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CH_W-1:0]     data_ch_q, data_ch_d;
    logic                data_valid_q, data_valid_d;
    logic [CH_W-1:0]     scan_ptr_q, scan_ptr_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                scan_frame_q, scan_frame_d;
    logic [FRAME_W-1:0]  cmd_q, cmd_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;

    logic [CH_W-1:0]     req_ch;
    logic [FRAME_W-1:0]  cmd_word;
    logic                cnt_last;
    logic [TOG_W-1:0]    tog_next;
    logic                sample_edge;

    // Next-state logic. The half-period counter runs in every non-idle
    // state; each time it wraps in SETUP/SHIFT an sclk toggle happens and
    // the toggle number decides whether it is a sampling or a shifting edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tog_d        = tog_q;
        sclk_d       = sclk_q;
        cs_n_d       = cs_n_q;
        mosi_d       = mosi_q;
        busy_d       = busy_q;
        data_d       = data_q;
        data_ch_d    = data_ch_q;
        data_valid_d = 1'b0;
        scan_ptr_d   = scan_ptr_q;
        ch_d         = ch_q;
        scan_frame_d = scan_frame_q;
        cmd_d        = cmd_q;
        shift_d      = shift_q;

        cnt_last    = (cnt_q == CNT_LAST);
        tog_next    = tog_q + 1'b1;
        // Odd toggles are leading edges; CPHA flips which edge samples.
        sample_edge = tog_next[0] ^ CPHA;

        // Scan wins over single-shot; an out-of-range request falls back to 0.
        if (scan_en) begin
            req_ch = scan_ptr_q;
        end else if (int'(ch_sel) >= NUM_CH) begin
            req_ch = '0;
        end else begin
            req_ch = ch_sel;
        end
        cmd_word                     = '0;
        cmd_word[FRAME_W-1]          = 1'b1;
        cmd_word[FRAME_W-2 -: CH_W]  = req_ch;

        if (state_q != S_IDLE) begin
            cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (scan_en || start) begin
                    state_d      = S_SETUP;
                    cnt_d        = '0;
                    tog_d        = '0;
                    cs_n_d       = 1'b0;
                    busy_d       = 1'b1;
                    ch_d         = req_ch;
                    scan_frame_d = scan_en;
                    shift_d      = '0;
                    // With CPHA=0 the first command bit must already be on
                    // mosi before the first (sampling) edge.
                    if (CPHA == 1'b0) begin
                        mosi_d = cmd_word[FRAME_W-1];
                        cmd_d  = FRAME_W'({cmd_word, 1'b0});
                    end else begin
                        mosi_d = 1'b0;
                        cmd_d  = cmd_word;
                    end
                end
            end
            S_SETUP, S_SHIFT: begin
                if (cnt_last) begin
                    sclk_d = ~sclk_q;
                    tog_d  = tog_next;
                    if (sample_edge) begin
                        shift_d = FRAME_W'({shift_q, miso});
                    end else begin
                        mosi_d = cmd_q[FRAME_W-1];
                        cmd_d  = FRAME_W'({cmd_q, 1'b0});
                    end
                    state_d = (tog_next == TOG_LAST) ? S_HOLD : S_SHIFT;
                end
            end
            S_HOLD: begin
                if (cnt_last) begin
                    state_d      = S_GAP;
                    cs_n_d       = 1'b1;
                    mosi_d       = 1'b0;
                    data_d       = shift_q[DATA_W-1:0];
                    data_ch_d    = ch_q;
                    data_valid_d = 1'b1;
                    if (scan_frame_q) begin
                        scan_ptr_d = (scan_ptr_q == CH_LAST) ? '0 : scan_ptr_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (cnt_last) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tog_q        <= '0;
            sclk_q       <= CPOL;
            cs_n_q       <= 1'b1;
            mosi_q       <= 1'b0;
            busy_q       <= 1'b0;
            data_q       <= '0;
            data_ch_q    <= '0;
            data_valid_q <= 1'b0;
            scan_ptr_q   <= '0;
            ch_q         <= '0;
            scan_frame_q <= 1'b0;
            cmd_q        <= '0;
            shift_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tog_q        <= tog_d;
            sclk_q       <= sclk_d;
            cs_n_q       <= cs_n_d;
            mosi_q       <= mosi_d;
            busy_q       <= busy_d;
            data_q       <= data_d;
            data_ch_q    <= data_ch_d;
            data_valid_q <= data_valid_d;
            scan_ptr_q   <= scan_ptr_d;
            ch_q         <= ch_d;
            scan_frame_q <= scan_frame_d;
            cmd_q        <= cmd_d;
            shift_q      <= shift_d;
        end
    end

    assign busy       = busy_q;
    assign data       = data_q;
    assign data_ch    = data_ch_q;
    assign data_valid = data_valid_q;
    assign sclk       = sclk_q;
    assign cs_n       = cs_n_q;
    assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_adc_scan_master.sv
// ---------------------------------------------------------------------------
// tb_spi_adc_scan_master
//
// Two instances: A uses the default configuration (16-bit frame, 12-bit
// result, 8 channels, CLK_DIV 4, mode 0); B uses a 12-bit frame, 10-bit
// result, 6 channels, CLK_DIV 2, CPOL=1/CPHA=1. A behavioural ADC slave per
// instance reacts to sclk edges, and a timing model derived from frame
// arithmetic predicts every output on every cycle.
// ---------------------------------------------------------------------------
module tb_spi_adc_scan_master;

    localparam int F_P    [2] = '{16, 12};
    localparam int D_P    [2] = '{12, 10};
    localparam int N_P    [2] = '{8, 6};
    localparam int K_P    [2] = '{4, 2};
    localparam int CPOL_P [2] = '{0, 1};
    localparam int CPHA_P [2] = '{0, 1};

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic scan_en;
    logic [2:0] ch_sel_a;
    logic [2:0] ch_sel_b;
    logic [1:0] miso;

    logic        busy_a, dv_a, sclk_a, cs_n_a, mosi_a;
    logic [11:0] data_a;
    logic [2:0]  data_ch_a;
    logic        busy_b, dv_b, sclk_b, cs_n_b, mosi_b;
    logic [9:0]  data_b;
    logic [2:0]  data_ch_b;

    logic [1:0]  busy_v, dv_v, sclk_v, cs_n_v, mosi_v;
    logic [15:0] data_v [2];
    logic [2:0]  data_ch_v [2];

    assign busy_v    = {busy_b, busy_a};
    assign dv_v      = {dv_b, dv_a};
    assign sclk_v    = {sclk_b, sclk_a};
    assign cs_n_v    = {cs_n_b, cs_n_a};
    assign mosi_v    = {mosi_b, mosi_a};
    assign data_v[0] = {4'b0, data_a};
    assign data_v[1] = {6'b0, data_b};
    assign data_ch_v[0] = data_ch_a;
    assign data_ch_v[1] = data_ch_b;

    spi_adc_scan_master #(
        .DATA_W(D_P[0]), .FRAME_W(F_P[0]), .NUM_CH(N_P[0]), .CH_W(3),
        .CLK_DIV(K_P[0]), .CPOL(1'b0), .CPHA(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .ch_sel(ch_sel_a), .scan_en(scan_en),
        .busy(busy_a), .data(data_a), .data_ch(data_ch_a), .data_valid(dv_a),
        .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a), .miso(miso[0])
    );

    spi_adc_scan_master #(
        .DATA_W(D_P[1]), .FRAME_W(F_P[1]), .NUM_CH(N_P[1]), .CH_W(3),
        .CLK_DIV(K_P[1]), .CPOL(1'b1), .CPHA(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .ch_sel(ch_sel_b), .scan_en(scan_en),
        .busy(busy_b), .data(data_b), .data_ch(data_ch_b), .data_valid(dv_b),
        .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .miso(miso[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_on = 1'b0;

    // Model state: one frame in flight per instance, described by when it
    // was accepted and what it carries.
    bit in_frame [2];
    int e_cyc    [2];
    int cur_ch   [2];
    int cur_word [2];
    bit cur_scan [2];
    int ptr_m    [2];
    int last_data[2];
    int last_ch  [2];
    bit force_on = 1'b0;
    int force_word [2];
    int model_o;

    // Slave / monitor state.
    bit prev_cs   [2] = '{1'b1, 1'b1};
    bit prev_sclk [2];
    int idx       [2];
    int low_cnt   [2];
    int rises     [2];
    int mosi_cap  [2];
    int fin_low   [2];
    int fin_rises [2];
    int fin_mosi  [2];
    int dv_cnt    [2];
    int dv_cyc    [2];
    int chq  [$];
    int cycq [$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h",
                     name, cyc, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit s, input bit sc, input logic [2:0] ca,
                                 input logic [2:0] cb);
        start    = s;
        scan_en  = sc;
        ch_sel_a = ca;
        ch_sel_b = cb;
        tick();
    endtask

    function automatic bit bitOf(input int w, input int i);
        return bit'((w >> i) & 1);
    endfunction

    // Frame-level model: a frame is accepted on an idle edge, data is due
    // (2F+1)*CLK_DIV edges later and the block is idle again CLK_DIV after.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                in_frame[k]  = 1'b0;
                ptr_m[k]     = 0;
                last_data[k] = 0;
                last_ch[k]   = 0;
            end else if (in_frame[k]) begin
                model_o = cyc - e_cyc[k];
                if (model_o == (2 * F_P[k] + 1) * K_P[k]) begin
                    last_data[k] = cur_word[k] & ((1 << D_P[k]) - 1);
                    last_ch[k]   = cur_ch[k];
                    if (cur_scan[k]) ptr_m[k] = (ptr_m[k] + 1) % N_P[k];
                end
                if (model_o == (2 * F_P[k] + 2) * K_P[k]) in_frame[k] = 1'b0;
            end else if (scan_en || start) begin
                in_frame[k] = 1'b1;
                e_cyc[k]    = cyc;
                cur_scan[k] = scan_en;
                if (scan_en) begin
                    cur_ch[k] = ptr_m[k];
                end else begin
                    cur_ch[k] = (k == 0) ? int'(ch_sel_a) : int'(ch_sel_b);
                    if (cur_ch[k] >= N_P[k]) cur_ch[k] = 0;
                end
                cur_word[k] = force_on ? force_word[k]
                                       : int'($urandom & ((32'd1 << F_P[k]) - 1));
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < 2; k++) begin
                int f, d, o, n, lowlen, cmd;
                bit eb, ecs, edv, esc, em;
                string p;
                p      = (k == 0) ? "A" : "B";
                f      = F_P[k];
                d      = K_P[k];
                lowlen = (2 * f + 1) * d;
                cmd    = (1 << (f - 1)) | (cur_ch[k] << (f - 4));
                eb = 0; ecs = 1; edv = 0; esc = bit'(CPOL_P[k]); em = 0;
                if (in_frame[k]) begin
                    o   = cyc - e_cyc[k];
                    n   = o / d;
                    if (n > 2 * f) n = 2 * f;
                    eb  = 1;
                    ecs = (o >= lowlen);
                    edv = (o == lowlen);
                    esc = bit'(CPOL_P[k]) ^ bit'(n & 1);
                    if (o >= lowlen) em = 0;
                    else if (CPHA_P[k] == 0) em = (n / 2 < f) ? bitOf(cmd, f - 1 - n / 2) : 1'b0;
                    else em = (n == 0) ? 1'b0 : bitOf(cmd, f - (n + 1) / 2);
                end
                checkOutput({p, ".busy"},       32'(busy_v[k]),    32'(eb));
                checkOutput({p, ".cs_n"},       32'(cs_n_v[k]),    32'(ecs));
                checkOutput({p, ".data_valid"}, 32'(dv_v[k]),      32'(edv));
                checkOutput({p, ".sclk"},       32'(sclk_v[k]),    32'(esc));
                checkOutput({p, ".mosi"},       32'(mosi_v[k]),    32'(em));
                checkOutput({p, ".data"},       32'(data_v[k]),    32'(last_data[k]));
                checkOutput({p, ".data_ch"},    32'(data_ch_v[k]), 32'(last_ch[k]));
            end
        end
    end

    // ADC slave: shifts its word out on the non-sampling sclk edge and
    // records mosi on the sampling edge; also logs data_valid events.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit cs, sc, leading;
            cs = cs_n_v[k];
            sc = sclk_v[k];
            if (prev_cs[k] && !cs) begin
                idx[k] = 0; low_cnt[k] = 0; rises[k] = 0; mosi_cap[k] = 0;
                if (CPHA_P[k] == 0) begin
                    miso[k] = bitOf(cur_word[k], F_P[k] - 1);
                    idx[k]  = 1;
                end
            end
            if (!cs) begin
                low_cnt[k]++;
                if (sc != prev_sclk[k]) begin
                    leading = (sc != bit'(CPOL_P[k]));
                    if (sc) rises[k]++;
                    if (leading ^ bit'(CPHA_P[k])) begin
                        mosi_cap[k] = (mosi_cap[k] << 1) | int'(mosi_v[k]);
                    end else if (idx[k] < F_P[k]) begin
                        miso[k] = bitOf(cur_word[k], F_P[k] - 1 - idx[k]);
                        idx[k]++;
                    end
                end
            end
            if (!prev_cs[k] && cs) begin
                fin_low[k]   = low_cnt[k];
                fin_rises[k] = rises[k];
                fin_mosi[k]  = mosi_cap[k];
            end
            if (dv_v[k] === 1'b1) begin
                dv_cnt[k]++;
                dv_cyc[k] = cyc;
                if (k == 0) begin
                    chq.push_back(int'(data_ch_v[0]));
                    cycq.push_back(cyc);
                end
            end
            prev_cs[k]   = cs;
            prev_sclk[k] = sc;
        end
    end

    initial begin
        int acc, base_a, base_b, waited;
        int exp_seq [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        rst = 1'b1; start = 1'b0; scan_en = 1'b0;
        ch_sel_a = 3'd0; ch_sel_b = 3'd0; miso = 2'b00;
        @(posedge clk);
        tick();
        cmp_on = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checkOutput("reset.A.cs_n", 32'(cs_n_a), 32'd1);
        checkOutput("reset.A.data", 32'(data_a), 32'd0);
        checkOutput("reset.B.sclk", 32'(sclk_b), 32'd1);

        // Single shot on both: A ch5 with 0x0ABC, B out-of-range ch7 with 0x3A5.
        $display("[TB] single-shot frames");
        force_on = 1'b1;
        force_word[0] = 32'h0ABC;
        force_word[1] = 32'h3A5;
        base_a = dv_cnt[0];
        base_b = dv_cnt[1];
        applyStimulus(1'b1, 1'b0, 3'd5, 3'd7);
        acc = cyc;
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0);
        repeat (38) tick();
        applyStimulus(1'b1, 1'b0, 3'd2, 3'd2);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0);
        waited = 0;
        while (dv_cnt[0] == base_a && waited < 400) begin
            tick();
            waited++;
        end
        repeat (20) tick();
        force_on = 1'b0;
        checkOutput("A.dv_count", 32'(dv_cnt[0] - base_a), 32'd1);
        checkOutput("A.dv_latency", 32'(dv_cyc[0] - acc), 32'd132);
        checkOutput("A.data_abc", 32'(data_a), 32'hABC);
        checkOutput("A.data_ch5", 32'(data_ch_a), 32'd5);
        checkOutput("A.cs_low", 32'(fin_low[0]), 32'd132);
        checkOutput("A.sclk_rises", 32'(fin_rises[0]), 32'd16);
        checkOutput("A.mosi_cmd", 32'(fin_mosi[0]), 32'hD000);
        checkOutput("B.dv_count", 32'(dv_cnt[1] - base_b), 32'd1);
        checkOutput("B.dv_latency", 32'(dv_cyc[1] - acc), 32'd50);
        checkOutput("B.data_3a5", 32'(data_b), 32'h3A5);
        checkOutput("B.data_ch0", 32'(data_ch_b), 32'd0);
        checkOutput("B.cs_low", 32'(fin_low[1]), 32'd50);
        checkOutput("B.sclk_rises", 32'(fin_rises[1]), 32'd12);
        checkOutput("B.mosi_cmd", 32'(fin_mosi[1]), 32'h800);
        checkOutput("B.sclk_idle", 32'(sclk_b), 32'd1);

        // Continuous scan with start pulses thrown in.
        $display("[TB] round-robin scan");
        chq.delete();
        cycq.delete();
        base_a = dv_cnt[0];
        waited = 0;
        while (dv_cnt[0] - base_a < 10 && waited < 1800) begin
            applyStimulus(($urandom_range(0, 9) == 0), 1'b1,
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            waited++;
        end
        checkOutput("A.scan_frames", 32'(dv_cnt[0] - base_a), 32'd10);
        if (chq.size() >= 10) begin
            for (int i = 0; i < 10; i++) begin
                checkOutput($sformatf("A.scan_ch%0d", i), 32'(chq[i]), 32'(exp_seq[i]));
            end
            checkOutput("A.scan_period_first", 32'(cycq[1] - cycq[0]), 32'd137);
            checkOutput("A.scan_period_last", 32'(cycq[9] - cycq[8]), 32'd137);
        end
        repeat ($urandom_range(10, 100)) applyStimulus(1'b0, 1'b1, 3'd0, 3'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0);
        repeat (300) tick();
        checkOutput("A.idle_after_scan", 32'(busy_a), 32'd0);
        checkOutput("B.idle_after_scan", 32'(busy_b), 32'd0);

        // Reset 60 cycles into a frame, then a clean frame.
        $display("[TB] mid-frame reset");
        applyStimulus(1'b1, 1'b0, 3'd4, 3'd1);
        start = 1'b0;
        repeat (59) tick();
        base_a = dv_cnt[0];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst.A.cs_n", 32'(cs_n_a), 32'd1);
        checkOutput("rst.A.sclk", 32'(sclk_a), 32'd0);
        checkOutput("rst.A.busy", 32'(busy_a), 32'd0);
        checkOutput("rst.B.sclk", 32'(sclk_b), 32'd1);
        repeat (150) tick();
        checkOutput("rst.A.no_dv", 32'(dv_cnt[0] - base_a), 32'd0);
        force_on = 1'b1;
        force_word[0] = 32'h1234;
        force_word[1] = 32'h0F0;
        applyStimulus(1'b1, 1'b0, 3'd3, 3'd3);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0);
        waited = 0;
        while (dv_cnt[0] == base_a && waited < 400) begin
            tick();
            waited++;
        end
        force_on = 1'b0;
        checkOutput("rst.A.clean_data", 32'(data_a), 32'h234);
        checkOutput("rst.A.clean_ch", 32'(data_ch_a), 32'd3);
        checkOutput("rst.B.clean_data", 32'(data_b), 32'h0F0);
        repeat (20) tick();

        // Randomised traffic, checked cycle by cycle against the model.
        $display("[TB] random traffic");
        begin
            bit sc;
            sc = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 199) == 0) sc = ~sc;
                rst = ($urandom_range(0, 1499) == 0);
                applyStimulus(($urandom_range(0, 7) == 0), sc,
                              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end
            rst = 1'b0;
            applyStimulus(1'b0, 1'b0, 3'd0, 3'd0);
            repeat (300) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
